// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers the hex digit shown per position.
// Optional SEG7_SYNC_EN adds a two-flop input synchronizer for asynchronous display sources.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   bad,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_e;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic [6:0]            seg_in;
  logic [NUM_DIGITS-1:0] dig_in;

`ifdef SEG7_SYNC_EN
  logic [6:0]            sy1_seg_q, sy2_seg_q;
  logic [NUM_DIGITS-1:0] sy1_dig_q, sy2_dig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy1_seg_q <= BLANK;
      sy2_seg_q <= BLANK;
      sy1_dig_q <= '1;
      sy2_dig_q <= '1;
    end else begin
      sy1_seg_q <= seg_n;
      sy2_seg_q <= sy1_seg_q;
      sy1_dig_q <= dig_n;
      sy2_dig_q <= sy1_dig_q;
    end
  end

  assign seg_in = sy2_seg_q;
  assign dig_in = sy2_dig_q;
`else
  assign seg_in = seg_n;
  assign dig_in = dig_n;
`endif

  // Result is {decodable, nibble}.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    case (p)
      7'b1000000: decode7 = 5'h10;
      7'b1111001: decode7 = 5'h11;
      7'b0100100: decode7 = 5'h12;
      7'b0110000: decode7 = 5'h13;
      7'b0011001: decode7 = 5'h14;
      7'b0010010: decode7 = 5'h15;
      7'b0000010: decode7 = 5'h16;
      7'b1111000: decode7 = 5'h17;
      7'b0000000: decode7 = 5'h18;
      7'b0011000: decode7 = 5'h19;
      7'b0001000: decode7 = 5'h1A;
      7'b0000011: decode7 = 5'h1B;
      7'b1000110: decode7 = 5'h1C;
      7'b0100001: decode7 = 5'h1D;
      7'b0000110: decode7 = 5'h1E;
      7'b0001110: decode7 = 5'h1F;
      default:    decode7 = 5'h00;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [6:0]              s_seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   s_dig_q, prev_dig_q;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, bad_q, bad_d;
  logic                    upd_q, upd_d;
  logic [2:0]              upd_idx_q, upd_idx_d;

  logic [3:0] zero_cnt;
  logic [2:0] sel_idx;
  logic       single, same, commit;
  logic [4:0] dec;

  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_dig_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        sel_idx  = 3'(i);
      end
    end
    single = (zero_cnt == 4'd1);
    same   = (s_seg_q == prev_seg_q) && (s_dig_q == prev_dig_q);
    dec    = decode7(s_seg_q);
  end

  // Next state: a commit happens only on the sample that brings an unbroken run up to the threshold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (single) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end
      end
      TRACK: begin
        if (!single) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (cnt_d == 8'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!single) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hex_d     = hex_q;
    valid_d   = valid_q;
    bad_d     = bad_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    if (commit) begin
      upd_d     = 1'b1;
      upd_idx_d = sel_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_idx == 3'(i)) begin
          if (dec[4]) begin
            hex_d[4*i +: 4] = dec[3:0];
            valid_d[i]      = 1'b1;
            bad_d[i]        = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            bad_d[i]   = (s_seg_q != BLANK);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_seg_q    <= BLANK;
      s_dig_q    <= '1;
      prev_seg_q <= BLANK;
      prev_dig_q <= '1;
      hex_q      <= '0;
      valid_q    <= '0;
      bad_q      <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_seg_q    <= seg_in;
      s_dig_q    <= dig_in;
      prev_seg_q <= s_seg_q;
      prev_dig_q <= s_dig_q;
      hex_q      <= hex_d;
      valid_q    <= valid_d;
      bad_q      <= bad_d;
      upd_q      <= upd_d;
      upd_idx_q  <= upd_idx_d;
    end
  end

  assign hex_out   = hex_q;
  assign valid     = valid_q;
  assign bad       = bad_q;
  assign upd       = upd_q;
  assign upd_idx   = upd_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed plan steps plus randomized scan traffic checked
// against a run-length reference model of the display bus.
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 8;
`ifdef SEG7_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg_n = 7'h7F;
  logic [ND-1:0]   dig_n = '1;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0]   valid, bad;
  logic            upd;
  logic [2:0]      upd_idx;
  logic [1:0]      dbg_state;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
    .hex_out(hex_out), .valid(valid), .bad(bad), .upd(upd),
    .upd_idx(upd_idx), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int upd_seen = 0;

  // Reference model: inputs delayed by the pipeline, then committed when a run of identical
  // single-digit samples reaches exactly SC in length.
  logic [10:0]     exp_q[$];
  logic [10:0]     last_e;
  int              run_len = 0;
  logic [4*ND-1:0] exp_hex = '0;
  logic [ND-1:0]   exp_valid = '0, exp_bad = '0;
  logic            exp_upd = 1'b0;
  logic [2:0]      exp_idx = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    lookup = -1;
    for (int k = 0; k < 16; k++) if (SEG_TBL[k] == p) lookup = k;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    run_len   = 0;
    last_e    = '1;
    exp_hex   = '0;
    exp_valid = '0;
    exp_bad   = '0;
    exp_upd   = 1'b0;
    exp_idx   = '0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] d);
    logic [10:0] e;
    int idx, nib, lows;
    exp_upd = 1'b0;
    exp_q.push_back({s, d});
    if (exp_q.size() > LAT) begin
      e = exp_q.pop_front();
      lows = 0;
      idx = 0;
      for (int k = 0; k < ND; k++) if (!e[k]) begin lows++; idx = k; end
      if (lows != 1) run_len = 0;
      else if (run_len > 0 && e == last_e) run_len++;
      else run_len = 1;
      last_e = e;
      if (run_len == SC) begin
        exp_upd = 1'b1;
        exp_idx = 3'(idx);
        nib = lookup(e[10:4]);
        if (nib >= 0) begin
          exp_hex[4*idx +: 4] = 4'(nib);
          exp_valid[idx] = 1'b1;
          exp_bad[idx]   = 1'b0;
        end else begin
          exp_valid[idx] = 1'b0;
          exp_bad[idx]   = (e[10:4] != 7'h7F);
        end
      end
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [ND-1:0] d);
    @(negedge clk);
    seg_n = s;
    dig_n = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
    chk("upd", 32'(upd), 32'(exp_upd));
    if (exp_upd) chk("upd_idx", 32'(upd_idx), 32'(exp_idx));
    chk("hex_out", 32'(hex_out), 32'(exp_hex));
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("bad", 32'(bad), 32'(exp_bad));
    if (upd) upd_seen++;
  endtask

  task automatic hold(input logic [6:0] s, input logic [ND-1:0] d, input int n);
    for (int k = 0; k < n; k++) step(s, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hex", 32'(hex_out), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_bad", 32'(bad), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    chk("rst_upd_idx", 32'(upd_idx), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    int n, segs;
    logic [6:0] s;
    logic [ND-1:0] d;
    model_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Stable digit 1 showing '2'
    upd_seen = 0;
    hold(7'b0100100, 4'b1101, 20);
    chk("stable_upd_count", 32'(upd_seen), 32'd1);
    chk("stable_nibble", 32'(hex_out[7:4]), 32'h2);
    chk("stable_valid", 32'(valid), 32'b0010);

    // Full scan A b C d
    upd_seen = 0;
    hold(7'b0001000, 4'b1110, 16);
    hold(7'b0000011, 4'b1101, 16);
    hold(7'b1000110, 4'b1011, 16);
    hold(7'b0100001, 4'b0111, 16);
    hold(7'h7F, 4'b1111, 4);
    chk("scan_upd_count", 32'(upd_seen), 32'd4);
    chk("scan_hex", 32'(hex_out), 32'hDCBA);
    chk("scan_valid", 32'(valid), 32'hF);

    // One-sample glitch never lets the count reach the threshold
    upd_seen = 0;
    hold(7'b1111000, 4'b1110, 7);
    hold(7'b0000000, 4'b1110, 1);
    hold(7'b1111000, 4'b1110, 7);
    hold(7'h7F, 4'b1111, 4);
    chk("glitch_upd_count", 32'(upd_seen), 32'd0);

    // Undecodable then blank on digit 2
    hold(7'b0101010, 4'b1011, 12);
    chk("bad2_bad", 32'(bad[2]), 32'd1);
    chk("bad2_valid", 32'(valid[2]), 32'd0);
    chk("bad2_hex_kept", 32'(hex_out[11:8]), 32'hC);
    hold(7'b1111111, 4'b1011, 12);
    chk("blank2_bad", 32'(bad[2]), 32'd0);
    chk("blank2_valid", 32'(valid[2]), 32'd0);

    // Multi-select stays idle
    upd_seen = 0;
    hold(7'b0100100, 4'b0011, 30);
    chk("multi_state", 32'(dbg_state), 32'd0);
    chk("multi_upd_count", 32'(upd_seen), 32'd0);

    // Reset in the middle of tracking discards the count
    hold(7'b0010010, 4'b1101, 5);
    do_reset();
    upd_seen = 0;
    hold(7'h7F, 4'b1111, 6);
    chk("rst_mid_upd_count", 32'(upd_seen), 32'd0);

    // Randomized scan traffic
    segs = 80;
    for (int t = 0; t < segs; t++) begin
      n = $urandom_range(1, 14);
      case ($urandom_range(0, 9))
        0: d = '1;
        1: d = ND'($urandom_range(0, 15));
        default: begin d = '1; d[$urandom_range(0, ND-1)] = 1'b0; end
      endcase
      case ($urandom_range(0, 9))
        0: s = 7'h7F;
        1: s = 7'($urandom_range(0, 127));
        default: s = SEG_TBL[$urandom_range(0, 15)];
      endcase
      hold(s, d, n);
    end
    hold(7'h7F, 4'b1111, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
